// File: rtl/pong_pkg.sv
// Shared definitions for the paddle-game datapath: state and direction
// encodings, default playfield geometry and a centring helper.
package pong_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_MISS = 2'd2;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    localparam int unsigned SCREEN_W_DEF    = 640;
    localparam int unsigned SCREEN_H_DEF    = 480;
    localparam int unsigned BALL_DEF        = 8;
    localparam int unsigned STEP_DEF        = 2;
    localparam int unsigned MISS_FRAMES_DEF = 60;

    function automatic logic [15:0] centre(input int unsigned extent, input int unsigned ball);
        return 16'((extent - ball) / 2);
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// One ball axis that reflects off both ends of [0, LIMIT]; moves by STEP on
// each enabled frame tick, and reloads INIT with positive direction on load.
module bounce_axis
    import pong_pkg::*;
#(
    parameter int unsigned LIMIT = 472,
    parameter int unsigned STEP  = 2,
    parameter logic [15:0] INIT  = 16'd236
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic        load,
    output logic [15:0] pos
);

    localparam logic [15:0] LIMIT16 = 16'(LIMIT);
    localparam logic [15:0] STEP16  = 16'(STEP);

    logic dir;

    // Limits are checked before stepping so the position never wraps.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            pos <= INIT;
            dir <= DIR_POS;
        end else if (frame_tick && enable) begin
            if (dir == DIR_POS) begin
                if ({1'b0, pos} + {1'b0, STEP16} >= {1'b0, LIMIT16}) begin
                    pos <= LIMIT16;
                    dir <= DIR_NEG;
                end else begin
                    pos <= pos + STEP16;
                end
            end else begin
                if (pos <= STEP16) begin
                    pos <= '0;
                    dir <= DIR_POS;
                end else begin
                    pos <= pos - STEP16;
                end
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Frame-rate ball engine: row axis via bounce_axis, column axis inline with
// paddle return, miss detection, rally score and the IDLE/MOVE/MISS sequence.
module ball_motion
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
    parameter int unsigned BALL        = BALL_DEF,
    parameter int unsigned STEP        = STEP_DEF,
    parameter int unsigned MISS_FRAMES = MISS_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic        paddle_hit,
    output logic [15:0] ballrow,
    output logic [15:0] ballcol,
    output logic [7:0]  score,
    output logic        hit,
    output logic        miss,
    output logic [1:0]  state
);

    localparam logic [15:0] ROW_INIT = centre(SCREEN_H, BALL);
    localparam logic [15:0] COL_INIT = centre(SCREEN_W, BALL);
    localparam logic [15:0] COL_MAX  = 16'(SCREEN_W - BALL);
    localparam logic [15:0] STEP16   = 16'(STEP);
    localparam int unsigned CNT_W    = $clog2(MISS_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             dx;
    logic [CNT_W-1:0] miss_cnt;
    logic             miss_done;
    logic             recentre;

    assign miss_done = (state == ST_MISS) && frame_tick && (miss_cnt == CNT_LAST);
    assign recentre  = ((state == ST_IDLE) && serve) || miss_done;

    bounce_axis #(
        .LIMIT (SCREEN_H - BALL),
        .STEP  (STEP),
        .INIT  (ROW_INIT)
    ) u_row (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .enable     (state == ST_MOVE),
        .load       (recentre),
        .pos        (ballrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ballcol  <= COL_INIT;
            dx       <= DIR_POS;
            score    <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            miss_cnt <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (serve) begin
                        state   <= ST_MOVE;
                        ballcol <= COL_INIT;
                        dx      <= DIR_POS;
                        score   <= '0;
                    end
                end
                ST_MOVE: begin
                    if (frame_tick) begin
                        if (dx == DIR_POS) begin
                            if ({1'b0, ballcol} + {1'b0, STEP16} >= {1'b0, COL_MAX}) begin
                                ballcol <= COL_MAX;
                                dx      <= DIR_NEG;
                            end else begin
                                ballcol <= ballcol + STEP16;
                            end
                        end else if (paddle_hit) begin
                            // A return beats a simultaneous left-edge arrival.
                            ballcol <= ballcol + STEP16;
                            dx      <= DIR_POS;
                            hit     <= 1'b1;
                            if (score != 8'hff) begin
                                score <= score + 8'd1;
                            end
                        end else if (ballcol <= STEP16) begin
                            ballcol  <= '0;
                            miss     <= 1'b1;
                            state    <= ST_MISS;
                            miss_cnt <= '0;
                        end else begin
                            ballcol <= ballcol - STEP16;
                        end
                    end
                end
                ST_MISS: begin
                    if (frame_tick) begin
                        if (miss_cnt == CNT_LAST) begin
                            state   <= ST_IDLE;
                            ballcol <= COL_INIT;
                            dx      <= DIR_POS;
                        end else begin
                            miss_cnt <= miss_cnt + CNT_ONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a vector table for the opening cycles, then
// long hand-computed trajectories through walls, a paddle return, misses and resets.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        serve = 1'b0;
    logic        paddle_hit = 1'b0;
    logic [15:0] ballrow;
    logic [15:0] ballcol;
    logic [7:0]  score;
    logic        hit;
    logic        miss;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .serve      (serve),
        .paddle_hit (paddle_hit),
        .ballrow    (ballrow),
        .ballcol    (ballcol),
        .score      (score),
        .hit        (hit),
        .miss       (miss),
        .state      (state)
    );

    typedef struct {
        logic        tick;
        logic        srv;
        logic        ph;
        logic [15:0] row;
        logic [15:0] col;
        logic [7:0]  scr;
        logic        h;
        logic        m;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] er, input logic [15:0] ec,
                         input logic [7:0] es, input logic eh, input logic em,
                         input logic [1:0] est);
        tests++;
        if (ballrow !== er || ballcol !== ec || score !== es || hit !== eh || miss !== em ||
            state !== est) begin
            fails++;
            $display("FAIL %s: got row=%0d col=%0d score=%0d hit=%0b miss=%0b state=%0d, want row=%0d col=%0d score=%0d hit=%0b miss=%0b state=%0d",
                     name, ballrow, ballcol, score, hit, miss, state, er, ec, es, eh, em, est);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then sample 1 ns later.
    task automatic cyc(input logic t, input logic s, input logic p);
        frame_tick = t;
        serve      = s;
        paddle_hit = p;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        serve      = 1'b0;
        paddle_hit = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'd238, 16'd318, 8'd0, 1'b0, 1'b0, 2'd1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 16'd238, 16'd318, 8'd0, 1'b0, 1'b0, 2'd1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 16'd240, 16'd320, 8'd0, 1'b0, 1'b0, 2'd1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 16'd242, 16'd322, 8'd0, 1'b0, 1'b0, 2'd1};

        @(posedge clk);
        do_reset();
        check("reset", 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd0);

        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].tick, vecs[i].srv, vecs[i].ph);
            check($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].scr,
                  vecs[i].h, vecs[i].m, vecs[i].st);
        end

        // Run 1: tick count since serve is 3 here.
        run(114);
        check("pre_bottom", 16'd470, 16'd550, 8'd0, 1'b0, 1'b0, 2'd1);
        run(1);
        check("bottom_clamp", 16'd472, 16'd552, 8'd0, 1'b0, 1'b0, 2'd1);
        run(1);
        check("bottom_flip", 16'd470, 16'd554, 8'd0, 1'b0, 1'b0, 2'd1);
        run(38);
        check("pre_right", 16'd394, 16'd630, 8'd0, 1'b0, 1'b0, 2'd1);
        run(1);
        check("right_clamp", 16'd392, 16'd632, 8'd0, 1'b0, 1'b0, 2'd1);
        run(1);
        check("right_flip", 16'd390, 16'd630, 8'd0, 1'b0, 1'b0, 2'd1);
        run(194);
        check("pre_top", 16'd2, 16'd242, 8'd0, 1'b0, 1'b0, 2'd1);
        run(1);
        check("top_clamp", 16'd0, 16'd240, 8'd0, 1'b0, 1'b0, 2'd1);
        run(1);
        check("top_flip", 16'd2, 16'd238, 8'd0, 1'b0, 1'b0, 2'd1);
        run(99);
        check("pre_hit", 16'd200, 16'd40, 8'd0, 1'b0, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 1'b1);
        check("hit_taken", 16'd202, 16'd42, 8'd1, 1'b1, 1'b0, 2'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("hit_one_cycle", 16'd202, 16'd42, 8'd1, 1'b0, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 1'b1);
        check("hit_ignored_dx_pos", 16'd204, 16'd44, 8'd1, 1'b0, 1'b0, 2'd1);
        run(609);
        check("pre_miss", 16'd466, 16'd2, 8'd1, 1'b0, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 1'b0);
        check("miss_taken", 16'd464, 16'd0, 8'd1, 1'b0, 1'b1, 2'd2);
        cyc(1'b0, 1'b0, 1'b0);
        check("miss_one_cycle", 16'd464, 16'd0, 8'd1, 1'b0, 1'b0, 2'd2);
        run(29);
        cyc(1'b1, 1'b0, 1'b1);
        check("miss_frozen_30", 16'd464, 16'd0, 8'd1, 1'b0, 1'b0, 2'd2);
        do_reset();
        check("reset_mid_miss", 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd0);

        // Run 2: same trajectory from a fresh serve, now through the full MISS hold.
        cyc(1'b0, 1'b1, 1'b0);
        check("serve2", 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd1);
        run(1);
        check("serve2_first", 16'd238, 16'd318, 8'd0, 1'b0, 1'b0, 2'd1);
        run(453);
        check("pre_hit2", 16'd200, 16'd40, 8'd0, 1'b0, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 1'b1);
        check("hit2", 16'd202, 16'd42, 8'd1, 1'b1, 1'b0, 2'd1);
        run(610);
        check("pre_miss2", 16'd466, 16'd2, 8'd1, 1'b0, 1'b0, 2'd1);
        run(1);
        check("miss2", 16'd464, 16'd0, 8'd1, 1'b0, 1'b1, 2'd2);
        run(59);
        check("miss_59", 16'd464, 16'd0, 8'd1, 1'b0, 1'b0, 2'd2);
        run(1);
        check("miss_60_idle", 16'd236, 16'd316, 8'd1, 1'b0, 1'b0, 2'd0);
        run(3);
        check("idle_score_held", 16'd236, 16'd316, 8'd1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check("serve3_clears", 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd1);

        // Run 3: take a return, then reset mid-MOVE.
        run(454);
        check("pre_hit3", 16'd200, 16'd40, 8'd0, 1'b0, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 1'b1);
        check("hit3", 16'd202, 16'd42, 8'd1, 1'b1, 1'b0, 2'd1);
        run(5);
        check("after_hit3", 16'd212, 16'd52, 8'd1, 1'b0, 1'b0, 2'd1);
        do_reset();
        check("reset_mid_move", 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd0);
        run(2);
        check("idle_after_reset", 16'd236, 16'd316, 8'd0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0);
        run(1);
        check("cold_serve_again", 16'd238, 16'd318, 8'd0, 1'b0, 1'b0, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
